tile_redraw_scheduler: RTL and testbench
========================================

TILE_REDRAW_SCHEDULER -- requirements
Module: tile_redraw_scheduler

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
REQ-003 SHALL: mineMap, flagMap, stepMap  in  64 each  per-tile board state; bit i = tile i.
REQ-004 SHALL: full_redraw  in  1  pulse; marks all 64 tiles dirty.
REQ-005 SHALL: draw_done  in  1  pulse from tile drawer; current tile finished.
REQ-006 SHALL: draw_start  out  1  one-cycle pulse; tile drawer begins tile_n.
REQ-007 SHALL: tile_n  out  6  tile being issued/drawn; row = tile_n[5:3], col = tile_n[2:0].
REQ-008 SHALL: tile_status  out  3  {mine, flag, step} of tile_n, captured at selection.
REQ-009 SHALL: busy  out  1  high when state != IDLE or any dirty bit set.
REQ-010 SHALL: frame_done  out  1  one-cycle pulse when the dirty set drains.
REQ-011 SHALL: timeout_err  out  1  one-cycle pulse on drawer timeout (REQ-027).

Function
REQ-012 SHALL: hold a 192-bit snapshot (3 bits/tile) of the last issued status and a 64-bit dirty vector.
REQ-013 SHALL: set dirty[i] on the edge after any of mineMap[i]/flagMap[i]/stepMap[i] differs from snapshot[i].
REQ-014 SHALL: set all dirty bits on the edge after full_redraw is high, in any state.
REQ-015 SHALL: implement states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-016 SHALL: in IDLE with dirty != 0, select one tile, latch tile_n and tile_status from current maps, write snapshot[tile], clear dirty[tile], go ISSUE; all on the same edge.
REQ-017 SHALL: on the selection edge the clear of dirty[selected] wins over a same-edge set from REQ-013 for that tile; a full_redraw on that edge wins over the clear.
REQ-018 SHALL: select round-robin: lowest dirty index >= ptr, else lowest dirty index overall; ptr <= selected+1 mod 64 (63 wraps to 0).
REQ-019 SHALL: assert draw_start exactly during the single ISSUE cycle, then go WAIT unconditionally.
REQ-020 SHALL: ignore draw_done in IDLE and ISSUE; in WAIT, draw_done moves to IDLE on that edge.
REQ-021 SHALL: hold tile_n and tile_status stable from ISSUE through the end of WAIT.
REQ-022 SHALL: latency map change (cycle t, IDLE, no other dirty) -> draw_start high in cycle t+2.
REQ-023 SHALL: re-dirty a tile whose maps change during its own ISSUE/WAIT (snapshot mismatch) so that it is redrawn with the new status.
REQ-024 SHALL: pulse frame_done on the cycle after the WAIT->IDLE edge when the dirty vector is zero after that edge.

Reset
REQ-025 SHALL: on reset: state IDLE, ptr 0, snapshot all 0, dirty all 1 (forces full-board draw), tile_n 0, tile_status 0, draw_start/frame_done/timeout_err 0.
REQ-026 SHALL: reset mid-ISSUE/WAIT abandon the tile without waiting for draw_done; the next draw_start is for tile 0.

Configuration
REQ-027 SHALL: with SCHED_TIMEOUT_EN defined, a 9-bit counter cleared on ISSUE counts in WAIT; on reaching 511 without draw_done: go IDLE, set dirty[tile_n], pulse timeout_err; draw_done on the same edge wins (no error).
REQ-028 SHALL: without SCHED_TIMEOUT_EN, WAIT persists until draw_done or reset and timeout_err is constant 0.

Verification
REQ-029 SHALL: reset 1 cycle, maps 0, draw_done 2 cycles after each draw_start -> 64 draw_starts, tile_n 0..63 in order, status 000, frame_done once after 64th, busy low after.
REQ-030 SHALL: idle, all clean, flagMap[10] 0->1 at cycle t -> draw_start at t+2, tile_n=10, tile_status=010, single pulse.
REQ-031 SHALL: after tile 40 served (ptr 41), tiles 5 and 50 dirtied same cycle -> tile 50 issued, then tile 5.
REQ-032 SHALL: stepMap[10] set during WAIT of tile 10 (status 000) -> after draw_done tile 10 reissued with status 001.
REQ-033 SHALL: reset pulse during WAIT of tile 30 -> no further tile 30 issue before a fresh draw_start with tile_n=0 and full 64-tile sequence.
REQ-034 SHALL: SCHED_TIMEOUT_EN defined, draw_done withheld for tile 7 -> timeout_err 1 cycle, tile 7 reissued; undefined -> busy held, no timeout_err, no reissue for 1000 cycles.

Source files
------------

// File: rtl/tile_redraw_scheduler.sv
// Dirty-tile redraw scheduler: tracks per-tile board changes and issues tiles to a drawer round-robin.
// Optional drawer watchdog enabled by defining SCHED_TIMEOUT_EN.
module tile_redraw_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] mineMap,
  input  logic [63:0] flagMap,
  input  logic [63:0] stepMap,
  input  logic        full_redraw,
  input  logic        draw_done,
  output logic        draw_start,
  output logic [5:0]  tile_n,
  output logic [2:0]  tile_status,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [63:0] dirty, dirty_nxt;
  logic [63:0] snap_mine, snap_flag, snap_step, mismatch;
  logic [5:0]  ptr, sel;
  logic        sel_valid, take, done_wait, timeout_hit;

  assign mismatch = (mineMap ^ snap_mine) | (flagMap ^ snap_flag) | (stepMap ^ snap_step);

  // Lowest dirty index overall, then overridden by the lowest at or above ptr if one exists.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int k = 63; k >= 0; k--) begin
      if (dirty[k]) begin
        sel       = 6'(k);
        sel_valid = 1'b1;
      end
    end
    for (int k = 63; k >= 0; k--) begin
      if (dirty[k] && (6'(k) >= ptr)) sel = 6'(k);
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [8:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                   wait_cnt <= '0;
    else if (state == ISSUE)                     wait_cnt <= '0;
    else if (state == WAIT && wait_cnt != 9'd511) wait_cnt <= wait_cnt + 9'd1;
  end

  assign timeout_hit = (state == WAIT) && !draw_done && (wait_cnt == 9'd511);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done_wait = 1'b0;
    case (state)
      IDLE:  if (sel_valid) begin
               state_nxt = ISSUE;
               take      = 1'b1;
             end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (draw_done || timeout_hit) begin
               state_nxt = IDLE;
               done_wait = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase

    // Priority: full_redraw > selection clear > change detect / timeout requeue.
    dirty_nxt = dirty | mismatch;
    if (timeout_hit) dirty_nxt[tile_n] = 1'b1;
    if (take)        dirty_nxt[sel]    = 1'b0;
    if (full_redraw) dirty_nxt         = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      dirty       <= '1;
      snap_mine   <= '0;
      snap_flag   <= '0;
      snap_step   <= '0;
      tile_n      <= '0;
      tile_status <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      dirty       <= dirty_nxt;
      frame_done  <= done_wait && (dirty_nxt == '0);
      timeout_err <= timeout_hit;
      if (take) begin
        tile_n         <= sel;
        tile_status    <= {mineMap[sel], flagMap[sel], stepMap[sel]};
        snap_mine[sel] <= mineMap[sel];
        snap_flag[sel] <= flagMap[sel];
        snap_step[sel] <= stepMap[sel];
        ptr            <= sel + 6'd1;
      end
    end
  end

  assign draw_start = (state == ISSUE);
  assign busy       = (state != IDLE) || (dirty != '0);

endmodule

// File: tb/tb_tile_redraw_scheduler.sv
// Bench for tile_redraw_scheduler: per-cycle comparison against a behavioural model plus directed scenarios.
// Honours SCHED_TIMEOUT_EN the same way the design does.
module tb_tile_redraw_scheduler;

  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] mineMap = '0, flagMap = '0, stepMap = '0;
  logic        full_redraw = 1'b0;
  logic        draw_done = 1'b0;
  logic        draw_start;
  logic [5:0]  tile_n;
  logic [2:0]  tile_status;
  logic        busy, frame_done, timeout_err;

  int checks = 0, errors = 0, cyc = 0, fd_count = 0;
  bit chk_en = 0;
  int dd_mode = 0;
  bit dd_force = 0;
  logic [1:0] dd_pipe = '0;

  int          m_phase, m_ptr, m_tile, m_wait;
  logic [2:0]  m_status;
  logic [2:0]  m_snap [64];
  logic [63:0] m_dirty;
  bit          m_fd, m_te;

  tile_redraw_scheduler dut (
    .clk(clk), .reset(reset),
    .mineMap(mineMap), .flagMap(flagMap), .stepMap(stepMap),
    .full_redraw(full_redraw), .draw_done(draw_done),
    .draw_start(draw_start), .tile_n(tile_n), .tile_status(tile_status),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: dirty set, snapshot per tile, round-robin search by modular scan.
  task automatic model_step();
    logic [63:0] nd;
    int  sel;
    bit  found, to_idle;
    cyc++;
    if (reset) begin
      m_phase = P_IDLE; m_ptr = 0; m_tile = 0; m_status = 0; m_wait = 0;
      for (int i = 0; i < 64; i++) m_snap[i] = 3'b000;
      m_dirty = '1; m_fd = 0; m_te = 0; chk_en = 1;
      return;
    end
    m_fd = 0; m_te = 0; to_idle = 0;
    nd = m_dirty;
    for (int i = 0; i < 64; i++)
      if ({mineMap[i], flagMap[i], stepMap[i]} != m_snap[i]) nd[i] = 1'b1;
    case (m_phase)
      P_IDLE: if (m_dirty != 0) begin
        found = 0; sel = 0;
        for (int k = 0; k < 64; k++)
          if (!found && m_dirty[(m_ptr + k) % 64]) begin found = 1; sel = (m_ptr + k) % 64; end
        m_tile = sel;
        m_status = {mineMap[sel], flagMap[sel], stepMap[sel]};
        m_snap[sel] = m_status;
        nd[sel] = 1'b0;
        m_ptr = (sel + 1) % 64;
        m_phase = P_ISSUE;
      end
      P_ISSUE: begin m_phase = P_WAIT; m_wait = 0; end
      default: begin
        if (draw_done) begin m_phase = P_IDLE; to_idle = 1; end
`ifdef SCHED_TIMEOUT_EN
        else if (m_wait == 511) begin
          m_phase = P_IDLE; to_idle = 1; nd[m_tile] = 1'b1; m_te = 1;
        end else m_wait++;
`endif
      end
    endcase
    if (full_redraw) nd = '1;
    if (to_idle && nd == 0) m_fd = 1;
    m_dirty = nd;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("draw_start", draw_start, m_phase == P_ISSUE);
      chk("tile_n", tile_n, m_tile);
      chk("tile_status", tile_status, m_status);
      chk("busy", busy, (m_phase != P_IDLE) || (m_dirty != 0));
      chk("frame_done", frame_done, m_fd);
      chk("timeout_err", timeout_err, m_te);
    end
    if (frame_done) fd_count++;
  end

  // Drawer: fixed 2-cycle reply, random replies, or silent.
  always @(negedge clk) begin
    case (dd_mode)
      0:       draw_done = dd_pipe[1];
      1:       draw_done = ($urandom_range(3) == 0);
      default: draw_done = 1'b0;
    endcase
    draw_done = draw_done | dd_force;
    dd_pipe = {dd_pipe[0], draw_start};
  end

  task automatic wait_start(input int maxc, output int t, output logic [2:0] st, output int at);
    t = -1; st = 3'b000; at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (draw_start) begin t = tile_n; st = tile_status; at = cyc; return; end
    end
    checks++; errors++;
    $display("FAIL wait_start no draw_start within %0d cycles, cycle=%0d", maxc, cyc);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle still busy after %0d cycles, cycle=%0d", maxc, cyc);
  endtask

  initial begin
    int t, at, t0, fd0, cnt_te, cnt_ds, cnt_lo;
    logic [2:0] st;
    int b;

    // Full-board draw out of reset.
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", busy, 1'b1);
    chk("reset_tile_n", tile_n, 6'd0);
    chk("reset_draw_start", draw_start, 1'b0);
    fd0 = fd_count;
    for (int i = 0; i < 64; i++) begin
      wait_start(20, t, st, at);
      chk("seq_tile", t, i);
      chk("seq_status", st, 3'b000);
    end
    repeat (5) @(negedge clk);
    chk("seq_frame_done_once", fd_count - fd0, 1);
    chk("seq_busy_low", busy, 1'b0);

    // Single change latency.
    flagMap[10] = 1'b1; t0 = cyc;
    wait_start(10, t, st, at);
    chk("lat_tile", t, 10);
    chk("lat_status", st, 3'b010);
    chk("lat_cycles", at - t0, 2);
    @(negedge clk);
    chk("lat_single_pulse", draw_start, 1'b0);
    wait_idle(20);

    // Round-robin after serving tile 40.
    mineMap[40] = 1'b1;
    wait_start(10, t, st, at);
    chk("rr_first40", t, 40);
    wait_idle(20);
    stepMap[5] = 1'b1; stepMap[50] = 1'b1;
    wait_start(10, t, st, at);
    chk("rr_tile50", t, 50);
    wait_start(20, t, st, at);
    chk("rr_tile5", t, 5);
    wait_idle(20);

    // Change during the tile's own WAIT.
    flagMap[10] = 1'b0;
    wait_start(10, t, st, at);
    chk("redirty_first", t, 10);
    chk("redirty_first_status", st, 3'b000);
    @(negedge clk);
    stepMap[10] = 1'b1;
    wait_start(20, t, st, at);
    chk("redirty_tile", t, 10);
    chk("redirty_status", st, 3'b001);
    wait_idle(20);

    // Reset during WAIT of tile 30.
    dd_mode = 2;
    mineMap[30] = 1'b1;
    wait_start(10, t, st, at);
    chk("rst_tile30", t, 30);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; dd_mode = 0;
    for (int i = 0; i < 64; i++) begin
      wait_start(20, t, st, at);
      chk("rst_seq_tile", t, i);
    end
    wait_idle(20);

    // Drawer never answers tile 7.
    dd_mode = 2;
    flagMap[7] = 1'b1;
    wait_start(10, t, st, at);
    chk("to_tile7", t, 7);
`ifdef SCHED_TIMEOUT_EN
    cnt_te = 0;
    for (int i = 0; i < 600 && cnt_te == 0; i++) begin
      @(negedge clk);
      if (timeout_err) cnt_te++;
    end
    chk("to_err_seen", cnt_te, 1);
    @(negedge clk);
    chk("to_err_pulse", timeout_err, 1'b0);
    wait_start(10, t, st, at);
    chk("to_reissue7", t, 7);
    dd_mode = 0;
    dd_force = 1'b1; @(negedge clk); dd_force = 1'b0;
`else
    cnt_te = 0; cnt_ds = 0; cnt_lo = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (timeout_err) cnt_te++;
      if (draw_start) cnt_ds++;
      if (!busy) cnt_lo++;
    end
    chk("nto_err", cnt_te, 0);
    chk("nto_reissue", cnt_ds, 0);
    chk("nto_busy_low", cnt_lo, 0);
    dd_force = 1'b1; @(negedge clk); dd_force = 1'b0;
    dd_mode = 0;
`endif
    wait_idle(50);

    // Randomised traffic.
    dd_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        b = $urandom_range(63);
        case ($urandom_range(2))
          0:       mineMap[b] = ~mineMap[b];
          1:       flagMap[b] = ~flagMap[b];
          default: stepMap[b] = ~stepMap[b];
        endcase
      end
      full_redraw = ($urandom_range(63) == 0);
      reset = ($urandom_range(699) == 0);
    end
    @(negedge clk);
    full_redraw = 1'b0; reset = 1'b0; dd_mode = 0;
    wait_idle(1000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
